// File: rtl/phy_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// phy_ctrl_pkg
// Shared definitions for the transmit-side phy link controller:
//   WORD_W        - width of a data word moved through the controller
//   ctrl_state_e  - controller FSM state encoding (exported on ctrl_state)
// ---------------------------------------------------------------------------
package phy_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_TRAIN  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/phy_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// phy_ctrl_fifo
// In-order synchronous FIFO used to hold words while the link trains.
// Push and pop may occur in the same cycle at any occupancy, including full
// (the pop frees the slot the push uses).
// Ports:
//   clk_f    in   clock (rising edge)
//   reset_L  in   asynchronous active-low reset; clears pointers and count
//   push     in   write wr_data this cycle
//   wr_data  in   DATA_W word to write
//   pop      in   remove the head word this cycle
//   rd_data  out  current head word (valid while empty is low)
//   full     out  FIFO holds DEPTH words
//   empty    out  FIFO holds no words
//   count    out  current occupancy
// ---------------------------------------------------------------------------
module phy_ctrl_fifo
  import phy_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WORD_W
) (
  input  logic                      clk_f,
  input  logic                      reset_L,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_f) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/phy_link_ctrl.sv
// ---------------------------------------------------------------------------
// phy_link_ctrl
// Transmit-side link controller in front of the phy datapath. Buffers
// upstream words while the lanes train, releases them once both lanes have
// been active for LOCK_CYCLES consecutive cycles, recirculates words that
// cannot be buffered, and on a training timeout flushes the buffer back to
// the source.
// Ports:
//   clk_f         in   block clock (rising edge)
//   reset_L       in   asynchronous active-low reset
//   valid_in      in   data_in valid
//   data_in       in   32-bit word from upstream
//   active_lane0  in   lane 0 active (synchronous to clk_f)
//   active_lane1  in   lane 1 active (synchronous to clk_f)
//   data_out      out  word to phy transmit input (holds when not valid)
//   valid_out     out  data_out valid
//   data_recirc   out  word returned to source (holds when not valid)
//   valid_recirc  out  data_recirc valid
//   link_up       out  high while in ACTIVE
//   ctrl_state    out  TRAIN=0, ACTIVE=1, FLUSH=2
//   drop_cnt      out  saturating count of words dropped during FLUSH
// ---------------------------------------------------------------------------
module phy_link_ctrl
  import phy_ctrl_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int LOCK_CYCLES   = 2,
  parameter int TRAIN_TIMEOUT = 16
) (
  input  logic        clk_f,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  input  logic        active_lane0,
  input  logic        active_lane1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic [31:0] data_recirc,
  output logic        valid_recirc,
  output logic        link_up,
  output logic [1:0]  ctrl_state,
  output logic [7:0]  drop_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int TO_W  = $clog2(TRAIN_TIMEOUT + 1);
  localparam logic [LK_W-1:0] LOCK_C = LK_W'(LOCK_CYCLES);
  localparam logic [TO_W-1:0] TO_C   = TO_W'(TRAIN_TIMEOUT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  ctrl_state_e       state_p1;
  ctrl_state_e       state_next_p0;
  logic [LK_W-1:0]   lock_cnt_p1;
  logic [LK_W-1:0]   lock_next_p0;
  logic [TO_W-1:0]   tmo_cnt_p1;
  logic [TO_W-1:0]   tmo_next_p0;

  logic              lanes_ok_p0;
  logic              push_p0;
  logic              pop_p0;
  logic              recirc_in_p0;
  logic              flush_pop_p0;
  logic              drop_p0;

  logic [WORD_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  phy_ctrl_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (WORD_W)
  ) u_fifo (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .push    (push_p0),
    .wr_data (data_in),
    .pop     (pop_p0),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign ctrl_state = state_p1;

  // ---- p0: decide this cycle's push/pop/recirc and next state ----
  always_comb begin
    lanes_ok_p0   = active_lane0 & active_lane1;
    push_p0       = 1'b0;
    pop_p0        = 1'b0;
    recirc_in_p0  = 1'b0;
    flush_pop_p0  = 1'b0;
    drop_p0       = 1'b0;
    lock_next_p0  = '0;
    tmo_next_p0   = '0;
    state_next_p0 = state_p1;

    case (state_p1)
      ST_TRAIN: begin
        push_p0      = valid_in & ~fifo_full;
        recirc_in_p0 = valid_in & fifo_full;
        lock_next_p0 = lanes_ok_p0 ? lock_cnt_p1 + LK_W'(1) : '0;
        tmo_next_p0  = tmo_cnt_p1 + TO_W'(1);
        // Lock is tested first so it wins a same-cycle timeout.
        if (lock_next_p0 == LOCK_C) begin
          state_next_p0 = ST_ACTIVE;
          lock_next_p0  = '0;
          tmo_next_p0   = '0;
        end else if (tmo_next_p0 == TO_C) begin
          lock_next_p0 = '0;
          tmo_next_p0  = '0;
          if (!fifo_empty) state_next_p0 = ST_FLUSH;
        end
      end

      ST_ACTIVE: begin
        // A lane dropping stops popping in the same cycle.
        if (!lanes_ok_p0) begin
          state_next_p0 = ST_TRAIN;
        end else begin
          pop_p0 = ~fifo_empty;
        end
        push_p0      = valid_in & (~fifo_full | pop_p0);
        recirc_in_p0 = valid_in & fifo_full & ~pop_p0;
      end

      ST_FLUSH: begin
        pop_p0       = ~fifo_empty;
        flush_pop_p0 = ~fifo_empty;
        drop_p0      = valid_in;
        if (fifo_empty || fifo_count == CNT_W'(1)) begin
          state_next_p0 = ST_TRAIN;
        end
      end

      default: state_next_p0 = ST_TRAIN;
    endcase
  end

  // ---- p1: state, counters and registered outputs ----
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_p1     <= ST_TRAIN;
      lock_cnt_p1  <= '0;
      tmo_cnt_p1   <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      data_recirc  <= '0;
      valid_recirc <= 1'b0;
      link_up      <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state_p1    <= state_next_p0;
      lock_cnt_p1 <= lock_next_p0;
      tmo_cnt_p1  <= tmo_next_p0;
      link_up     <= (state_next_p0 == ST_ACTIVE);

      valid_out <= pop_p0 & ~flush_pop_p0;
      if (pop_p0 && !flush_pop_p0) data_out <= fifo_rd_data;

      // Overflow recirculation and flush pops never coincide.
      valid_recirc <= recirc_in_p0 | flush_pop_p0;
      if (recirc_in_p0) begin
        data_recirc <= data_in;
      end else if (flush_pop_p0) begin
        data_recirc <= fifo_rd_data;
      end

      if (drop_p0) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

endmodule

// File: tb/tb_phy_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phy_link_ctrl
// Directed testbench for phy_link_ctrl with a queue-based reference model
// and per-cycle comparison, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_phy_link_ctrl;

  localparam int DEPTH = 4;
  localparam int LOCK  = 2;
  localparam int TMO   = 16;

  logic        clk_f = 1'b0;
  logic        reset_L = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        active_lane0 = 1'b0;
  logic        active_lane1 = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic [31:0] data_recirc;
  logic        valid_recirc;
  logic        link_up;
  logic [1:0]  ctrl_state;
  logic [7:0]  drop_cnt;

  phy_link_ctrl #(
    .DEPTH         (DEPTH),
    .LOCK_CYCLES   (LOCK),
    .TRAIN_TIMEOUT (TMO)
  ) dut (
    .clk_f        (clk_f),
    .reset_L      (reset_L),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .active_lane0 (active_lane0),
    .active_lane1 (active_lane1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .data_recirc  (data_recirc),
    .valid_recirc (valid_recirc),
    .link_up      (link_up),
    .ctrl_state   (ctrl_state),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk_f = ~clk_f;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model: buffered words as a queue, mode as 0/1/2.
  logic [31:0] mq[$];
  int          m_state = 0;
  int          m_lock = 0;
  int          m_tmo = 0;
  int          m_drop = 0;
  logic [31:0] m_dout = '0;
  logic [31:0] m_drc = '0;
  bit          m_vout = 1'b0;
  bit          m_vrc = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_lock = 0; m_tmo = 0; m_drop = 0;
    m_dout = '0; m_drc = '0; m_vout = 1'b0; m_vrc = 1'b0;
  endtask

  task automatic model_offer();
    if (valid_in) begin
      if (mq.size() < DEPTH) mq.push_back(data_in);
      else begin
        m_drc = data_in;
        m_vrc = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    int n = mq.size();
    bit both = active_lane0 && active_lane1;
    m_vout = 1'b0;
    m_vrc  = 1'b0;
    case (m_state)
      0: begin
        model_offer();
        m_lock = both ? m_lock + 1 : 0;
        m_tmo  = m_tmo + 1;
        if (m_lock >= LOCK) begin
          m_state = 1; m_lock = 0; m_tmo = 0;
        end else if (m_tmo >= TMO) begin
          m_lock = 0; m_tmo = 0;
          if (n > 0) m_state = 2;
        end
      end
      1: begin
        if (!both) m_state = 0;
        else if (mq.size() > 0) begin
          m_dout = mq.pop_front();
          m_vout = 1'b1;
        end
        model_offer();
      end
      default: begin
        if (mq.size() > 0) begin
          m_drc = mq.pop_front();
          m_vrc = 1'b1;
        end
        if (valid_in && m_drop < 255) m_drop++;
        if (mq.size() == 0) m_state = 0;
      end
    endcase
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_f) begin
    if (cmp_en) begin
      check("m_valid_out",    32'(valid_out),    32'(m_vout));
      check("m_data_out",     data_out,          m_dout);
      check("m_valid_recirc", 32'(valid_recirc), 32'(m_vrc));
      check("m_data_recirc",  data_recirc,       m_drc);
      check("m_link_up",      32'(link_up),      32'(m_state == 1));
      check("m_ctrl_state",   32'(ctrl_state),   32'(m_state));
      check("m_drop_cnt",     32'(drop_cnt),     32'(m_drop));
    end
  end

  task automatic cyc(input bit vi, input logic [31:0] d, input bit l0, input bit l1);
    valid_in = vi; data_in = d; active_lane0 = l0; active_lane1 = l1;
    @(posedge clk_f);
    model_step();
    @(negedge clk_f);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_f);
    reset_L = 1'b1;
    cmp_en  = 1'b1;

    // Buffered link-up
    cyc(1, 32'hA000_0001, 0, 0);
    cyc(1, 32'hA000_0002, 0, 0);
    cyc(1, 32'hA000_0003, 0, 0);
    cyc(0, 0, 1, 1);
    check("lock_one_cycle_state", 32'(ctrl_state), 32'd0);
    cyc(0, 0, 1, 1);
    check("linkup_link_up", 32'(link_up), 32'd1);
    check("linkup_state", 32'(ctrl_state), 32'd1);
    cyc(0, 0, 1, 1);
    check("linkup_word0", data_out, 32'hA000_0001);
    check("linkup_valid0", 32'(valid_out), 32'd1);
    cyc(0, 0, 1, 1);
    check("linkup_word1", data_out, 32'hA000_0002);
    cyc(0, 0, 1, 1);
    check("linkup_word2", data_out, 32'hA000_0003);
    cyc(0, 0, 1, 1);
    check("linkup_drained", 32'(valid_out), 32'd0);

    // Lane drop with two words queued
    cyc(0, 0, 0, 0);
    check("drop_to_train", 32'(ctrl_state), 32'd0);
    cyc(1, 32'hD000_0001, 0, 0);
    cyc(1, 32'hD000_0002, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    check("drop_active", 32'(ctrl_state), 32'd1);
    cyc(0, 0, 1, 0);
    check("drop_state", 32'(ctrl_state), 32'd0);
    check("drop_no_word", 32'(valid_out), 32'd0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    check("drop_relock", 32'(ctrl_state), 32'd1);
    cyc(0, 0, 1, 1);
    check("drop_resume0", data_out, 32'hD000_0001);
    cyc(0, 0, 1, 1);
    check("drop_resume1", data_out, 32'hD000_0002);

    // Lock glitch
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    check("glitch_no_active", 32'(ctrl_state), 32'd0);
    cyc(0, 0, 1, 1);
    check("glitch_then_lock", 32'(ctrl_state), 32'd1);
    cyc(0, 0, 0, 0);

    // Overflow recirculation, then timeout flush of B0..B3
    for (int i = 0; i < 6; i++) begin
      cyc(1, 32'hB000_0000 + 32'(i), 0, 0);
      if (i == 4) begin
        check("ovf_valid_b4", 32'(valid_recirc), 32'd1);
        check("ovf_data_b4", data_recirc, 32'hB000_0004);
      end
      if (i == 5) check("ovf_data_b5", data_recirc, 32'hB000_0005);
    end
    repeat (10) cyc(0, 0, 0, 0);
    check("ovf_flush_state", 32'(ctrl_state), 32'd2);
    repeat (4) cyc(0, 0, 0, 0);
    check("ovf_flush_last", data_recirc, 32'hB000_0003);
    check("ovf_flush_done", 32'(ctrl_state), 32'd0);

    // Timeout flush with drop during FLUSH
    cyc(1, 32'h0000_00C1, 0, 0);
    cyc(1, 32'h0000_00C2, 0, 0);
    repeat (14) cyc(0, 0, 0, 0);
    check("tmo_state_flush", 32'(ctrl_state), 32'd2);
    cyc(1, 32'hDEAD_0000, 0, 0);
    check("tmo_recirc_c1", data_recirc, 32'h0000_00C1);
    check("tmo_drop_cnt", 32'(drop_cnt), 32'd1);
    cyc(0, 0, 0, 0);
    check("tmo_recirc_c2", data_recirc, 32'h0000_00C2);
    check("tmo_back_train", 32'(ctrl_state), 32'd0);

    // Asynchronous reset with three words queued
    cyc(1, 32'hE000_0001, 0, 0);
    cyc(1, 32'hE000_0002, 0, 0);
    cyc(1, 32'hE000_0003, 0, 0);
    valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check("rst_data_out", data_out, 32'd0);
    check("rst_data_recirc", data_recirc, 32'd0);
    check("rst_valids", {30'd0, valid_out, valid_recirc}, 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_state", 32'(ctrl_state), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk_f);
    @(negedge clk_f);
    reset_L = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);
    check("post_rst_valid_out", 32'(valid_out), 32'd0);
    check("post_rst_valid_recirc", 32'(valid_recirc), 32'd0);

    // Two-cycle latency through an empty FIFO in ACTIVE
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    check("lat_active", 32'(ctrl_state), 32'd1);
    cyc(1, 32'hF000_0001, 1, 1);
    check("lat_not_yet", 32'(valid_out), 32'd0);
    cyc(0, 0, 1, 1);
    check("lat_word", data_out, 32'hF000_0001);
    check("lat_valid", 32'(valid_out), 32'd1);

    // Timeout with an empty FIFO stays in TRAIN
    cyc(0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    check("empty_tmo_train", 32'(ctrl_state), 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phy_link_ctrl.md
Name: phy_link_ctrl

Overview:
Transmit-side link controller in front of the phy datapath, clocked in the clk_f domain.
- Sequences the phy: holds traffic while lanes train, releases it once both lanes report active, and recirculates words it cannot accept.
- Buffers incoming 32-bit words in a small FIFO so that link-up does not lose data.
- On training timeout, flushes the buffered words to the recirculation return path.

Parameters:
DEPTH, 4, FIFO depth in words; power of two, minimum 2.
LOCK_CYCLES, 2, consecutive clk_f cycles with both lanes active required before entering ACTIVE.
TRAIN_TIMEOUT, 16, number of TRAIN cycles without lock before FLUSH.

Ports:
clk_f  in  1  single block clock; all logic is on its rising edge.
reset_L  in  1  asynchronous, active-low reset.
valid_in  in  1  data_in is valid this cycle.
data_in  in  32  word from the upstream source.
active_lane0  in  1  lane 0 active status from the phy receiver, already synchronous to clk_f.
active_lane1  in  1  lane 1 active status, same properties as active_lane0.
data_out  out  32  word to the phy transmit input.
valid_out  out  1  data_out is valid.
data_recirc  out  32  word returned to the source.
valid_recirc  out  1  data_recirc is valid.
link_up  out  1  high while state is ACTIVE.
ctrl_state  out  2  FSM state: TRAIN=0, ACTIVE=1, FLUSH=2.
drop_cnt  out  8  saturating count of words dropped during FLUSH.

Behaviour:
Reset
- Asserting reset_L low clears, immediately: all outputs to 0, FIFO pointers and count, lock counter, timeout counter; state goes to TRAIN.
- Reset mid-operation discards all FIFO contents.

Registered outputs
- data_out, valid_out, data_recirc, valid_recirc are all registered.
- data_out and data_recirc hold their last value when the matching valid is low.
- The FIFO is in-order. Push and pop in the same cycle are legal at any occupancy, including full.

TRAIN
- valid_in with FIFO not full: push.
- valid_in with FIFO full: word goes to data_recirc, valid_recirc=1 the next cycle.
- No pops.
- Lock counter increments while active_lane0 and active_lane1 are both 1; it resets to 0 when either is 0.
- Timeout counter increments every TRAIN cycle.
- Lock counter reaches LOCK_CYCLES: go to ACTIVE, timeout counter cleared. Lock wins if lock and timeout occur in the same cycle.
- Timeout counter reaches TRAIN_TIMEOUT with FIFO non-empty: go to FLUSH.
- Timeout counter reaches TRAIN_TIMEOUT with FIFO empty: stay in TRAIN, counters cleared.

ACTIVE
- Pop one word per cycle while the FIFO is non-empty. The popped word appears on data_out with valid_out=1 the next cycle.
- Pushes follow the same rules as TRAIN, so a full FIFO with no pop recirculates the incoming word.
- Word latency through an empty FIFO in ACTIVE: 2 cycles (push, then pop/register).
- Either lane 0 in a cycle: go to TRAIN on that edge with counters cleared. Pops stop from that cycle on; a word popped in the same cycle is still delivered.

FLUSH
- Pop one word per cycle to data_recirc with valid_recirc=1 the next cycle; valid_out=0.
- valid_in words are not pushed; each increments drop_cnt, saturating at 255.
- The pop that empties the FIFO moves the state to TRAIN with counters cleared.
- Lanes are ignored in FLUSH.
- drop_cnt clears only on reset.

Decomposition:
- Shared package phy_ctrl_pkg: state encoding constants (ST_TRAIN, ST_ACTIVE, ST_FLUSH) and the 32-bit word width constant.
- One sub-module, phy_ctrl_fifo: parameterised synchronous FIFO with push, pop, full, empty and count. The FSM, counters and output registers stay in phy_link_ctrl.

Test Plan:
- Reset/idle: reset_L=0 mid-stream with 3 words queued -> all outputs 0 and ctrl_state=0 immediately. After release, no valid_out or valid_recirc until new input.
- Buffered link-up: push 0xA0000001..0xA0000003 in TRAIN, then both lanes high for 2 cycles -> link_up=1. data_out shows 0xA0000001, 0xA0000002, 0xA0000003 on 3 consecutive cycles, in order.
- Overflow recirc: lanes low, push 6 words 0xB0..0xB5 -> FIFO holds 0xB0..0xB3. 0xB4 and 0xB5 appear on data_recirc one cycle after their input.
- Timeout flush: lanes low, push 0xC1 and 0xC2, wait 16 TRAIN cycles -> ctrl_state=2, data_recirc=0xC1 then 0xC2, then ctrl_state=0. valid_in during FLUSH -> drop_cnt=1.
- Lane drop: in ACTIVE with 2 words queued, active_lane1=0 for 1 cycle -> ctrl_state=0 next edge, at most 1 word emitted. Remaining word resumes after 2 lock cycles.
- Lock glitch: lanes high 1 cycle, low 1 cycle, high 1 cycle -> no ACTIVE. Lanes high 2 consecutive cycles -> ACTIVE.
